// File: rtl/point_loader.sv
// Elliptic-curve point loader: assembles x then y from narrow input words, waits for the
// external curve checker to settle, then publishes the point with range/on-curve flags.
//
// state     | meaning
// ST_LOAD_X | accepting x words, least-significant first
// ST_LOAD_Y | accepting y words, least-significant first
// ST_SETTLE | coordinates held stable while the curve checker settles
// ST_OUT    | result presented, waiting for out_ready
module point_loader #(
  parameter int LEN    = 256,
  parameter int WORD   = 32,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LEN-1:0]  p,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  output logic [LEN-1:0]  chk_x,
  output logic [LEN-1:0]  chk_y,
  input  logic            chk_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LEN-1:0]  out_x,
  output logic [LEN-1:0]  out_y,
  output logic            out_on_curve,
  output logic            out_range_err
);

  localparam int NW   = LEN / WORD;
  localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {ST_LOAD_X, ST_LOAD_Y, ST_SETTLE, ST_OUT} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [3:0]      settle_cnt;
  logic            xfer;
  logic            last_word;
  logic            range_err;

  // Gated by rst so the block never advertises readiness during a reset cycle.
  assign in_ready  = !rst && ((state == ST_LOAD_X) || (state == ST_LOAD_Y));
  assign xfer      = in_valid && in_ready;
  assign last_word = (idx == IDXW'(NW - 1));
  assign range_err = (chk_x >= p) || (chk_y >= p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOAD_X;
      idx           <= '0;
      settle_cnt    <= '0;
      chk_x         <= '0;
      chk_y         <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_valid     <= 1'b0;
      out_on_curve  <= 1'b0;
      out_range_err <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_X: begin
          if (xfer) begin
            chk_x[int'(idx)*WORD +: WORD] <= in_data;
            if (last_word) begin
              idx   <= '0;
              state <= ST_LOAD_Y;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_LOAD_Y: begin
          if (xfer) begin
            chk_y[int'(idx)*WORD +: WORD] <= in_data;
            if (last_word) begin
              idx        <= '0;
              settle_cnt <= 4'(SETTLE - 1);
              state      <= ST_SETTLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            out_x         <= chk_x;
            out_y         <= chk_y;
            out_range_err <= range_err;
            out_on_curve  <= chk_valid && !range_err;
            out_valid     <= 1'b1;
            state         <= ST_OUT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_LOAD_X;
          end
        end
        default: state <= ST_LOAD_X;
      endcase
    end
  end

endmodule

// File: tb/tb_point_loader.sv
// Directed bench for point_loader on a toy curve y^2 = x^3 + 2x + 3 mod 97, 16-bit coords.
module tb_point_loader;

  localparam int LEN    = 16;
  localparam int WORD   = 8;
  localparam int SETTLE = 2;
  localparam logic [LEN-1:0] P = 16'd97;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [LEN-1:0]  p = P;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WORD-1:0] in_data = '0;
  logic [LEN-1:0]  chk_x, chk_y;
  logic            chk_valid;
  logic            force_valid = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LEN-1:0]  out_x, out_y;
  logic            out_on_curve, out_range_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  point_loader #(.LEN(LEN), .WORD(WORD), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .p(p),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .chk_x(chk_x), .chk_y(chk_y), .chk_valid(chk_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y),
    .out_on_curve(out_on_curve), .out_range_err(out_range_err)
  );

  // Curve checker model; force_valid lets a test claim on-curve for an out-of-range point.
  always_comb begin
    longint unsigned xv, yv, lhs, rhs;
    xv = 64'(chk_x);
    yv = 64'(chk_y);
    lhs = (yv * yv) % 97;
    rhs = ((((xv * xv) % 97) * xv) + 2 * xv + 3) % 97;
    chk_valid = (lhs == rhs) || force_valid;
  end

  task automatic send_word(input logic [7:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_word timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_point(input logic [15:0] x, input logic [15:0] y, input bit gaps);
    send_word(x[7:0],  gaps ? int'($urandom_range(0, 1)) : 0);
    send_word(x[15:8], gaps ? int'($urandom_range(0, 1)) : 0);
    send_word(y[7:0],  gaps ? int'($urandom_range(0, 1)) : 0);
    send_word(y[15:8], gaps ? int'($urandom_range(0, 1)) : 0);
  endtask

  // Waits for out_valid (bounded), samples the result, then completes the handshake.
  task automatic collect(output int lat, output logic [15:0] gx, output logic [15:0] gy,
                         output logic goc, output logic gre);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = out_valid ? n : -1;
    gx = out_x; gy = out_y; goc = out_on_curve; gre = out_range_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    tests++;
    if ({out_valid, out_on_curve, out_range_err} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_on_curve, out_range_err});
    end
    tests++;
    if ({out_x, out_y, chk_x, chk_y} !== 64'h0) begin
      fails++; $display("FAIL reset_coords: got %h want 0", {out_x, out_y, chk_x, chk_y});
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_on_curve;
    int lat; logic [15:0] gx, gy; logic goc, gre;
    send_point(16'd3, 16'd6, 1'b0);
    collect(lat, gx, gy, goc, gre);
    tests++;
    if (lat !== SETTLE) begin fails++; $display("FAIL on_curve_latency: got %0d want %0d", lat, SETTLE); end
    tests++;
    if ({gx, gy, goc, gre} !== {16'd3, 16'd6, 1'b1, 1'b0}) begin
      fails++; $display("FAIL on_curve_result: got x=%0d y=%0d oc=%0b re=%0b want 3 6 1 0", gx, gy, goc, gre);
    end
  endtask

  task automatic test_off_curve;
    int lat; logic [15:0] gx, gy; logic goc, gre;
    send_point(16'd3, 16'd7, 1'b0);
    collect(lat, gx, gy, goc, gre);
    tests++;
    if ({gx, gy, goc, gre} !== {16'd3, 16'd7, 1'b0, 1'b0}) begin
      fails++; $display("FAIL off_curve_result: got x=%0d y=%0d oc=%0b re=%0b want 3 7 0 0", gx, gy, goc, gre);
    end
  endtask

  task automatic test_range;
    int lat; logic [15:0] gx, gy; logic goc, gre;
    force_valid = 1'b1;
    send_point(16'd97, 16'd6, 1'b0);
    collect(lat, gx, gy, goc, gre);
    force_valid = 1'b0;
    tests++;
    if ({gx, gy, goc, gre} !== {16'd97, 16'd6, 1'b0, 1'b1}) begin
      fails++; $display("FAIL range_x_eq_p: got x=%0d y=%0d oc=%0b re=%0b want 97 6 0 1", gx, gy, goc, gre);
    end
    send_point(16'd3, 16'd97, 1'b0);
    collect(lat, gx, gy, goc, gre);
    tests++;
    if ({goc, gre} !== 2'b01) begin
      fails++; $display("FAIL range_y_eq_p: got oc=%0b re=%0b want 0 1", goc, gre);
    end
    send_point(16'd96, 16'd6, 1'b0);
    collect(lat, gx, gy, goc, gre);
    tests++;
    if ({gx, gy, goc, gre} !== {16'd96, 16'd6, 1'b0, 1'b0}) begin
      fails++; $display("FAIL range_x_p_minus_1: got x=%0d y=%0d oc=%0b re=%0b want 96 6 0 0", gx, gy, goc, gre);
    end
  endtask

  task automatic test_stall;
    int n, lat; logic [15:0] gx, gy; logic goc, gre;
    logic [15:0] cx, cy; logic coc, cre;
    send_point(16'd3, 16'd6, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests++;
    if ({out_x, out_y, out_on_curve, out_range_err} !== {16'd3, 16'd6, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stall_result: got x=%0d y=%0d oc=%0b re=%0b want 3 6 1 0",
                        out_x, out_y, out_on_curve, out_range_err);
    end
    cx = out_x; cy = out_y; coc = out_on_curve; cre = out_range_err;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({out_valid, out_x, out_y, out_on_curve, out_range_err, in_ready} !== {1'b1, cx, cy, coc, cre, 1'b0}) begin
        fails++; $display("FAIL stall_hold cycle %0d: got v=%0b x=%0d y=%0d ir=%0b want v=1 x=%0d y=%0d ir=0",
                          i, out_valid, out_x, out_y, in_ready, cx, cy);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL accept_cycle_in_ready: got %0b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL after_accept: got v=%0b ir=%0b want v=0 ir=1", out_valid, in_ready);
    end
    send_point(16'd3, 16'd7, 1'b1);
    collect(lat, gx, gy, goc, gre);
    tests++;
    if ({gx, gy, goc} !== {16'd3, 16'd7, 1'b0}) begin
      fails++; $display("FAIL no_stray_word: got x=%0d y=%0d oc=%0b want 3 7 0", gx, gy, goc);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] gx, gy; logic goc, gre;
    logic seen;
    send_word(8'd5, 0);
    send_word(8'd0, 0);
    send_word(8'd9, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({chk_x, chk_y} !== 32'h0) begin
      fails++; $display("FAIL mid_reset_clear: got x=%0d y=%0d want 0 0", chk_x, chk_y);
    end
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= out_valid; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL mid_reset_no_out: got out_valid seen=%0b want 0", seen); end
    send_point(16'd3, 16'd6, 1'b0);
    collect(lat, gx, gy, goc, gre);
    tests++;
    if ({lat, gx, gy, goc, gre} !== {SETTLE, 16'd3, 16'd6, 1'b1, 1'b0}) begin
      fails++; $display("FAIL mid_reset_next: got lat=%0d x=%0d y=%0d oc=%0b re=%0b want %0d 3 6 1 0",
                        lat, gx, gy, goc, gre, SETTLE);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ex[4], ey[4];
    logic        eoc[4], ere[4];
    logic [7:0]  words[16];
    int wi, ri, cyc;
    logic xfer, hs, seen;
    ex = '{16'd3, 16'd3, 16'd97, 16'd96};
    ey = '{16'd6, 16'd91, 16'd6, 16'd6};
    eoc = '{1'b1, 1'b1, 1'b0, 1'b0};
    ere = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      words[4*k]   = ex[k][7:0];
      words[4*k+1] = ex[k][15:8];
      words[4*k+2] = ey[k][7:0];
      words[4*k+3] = ey[k][15:8];
    end
    wi = 0; ri = 0; cyc = 0;
    out_ready = 1'b1;
    while (ri < 4 && cyc < 300) begin
      in_valid = (wi < 16);
      in_data  = (wi < 16) ? words[wi] : 8'h00;
      #1;
      xfer = in_valid && in_ready;
      hs   = out_valid && out_ready;
      if (hs) begin
        tests++;
        if ({out_x, out_y, out_on_curve, out_range_err} !== {ex[ri], ey[ri], eoc[ri], ere[ri]}) begin
          fails++; $display("FAIL b2b_point %0d: got x=%0d y=%0d oc=%0b re=%0b want x=%0d y=%0d oc=%0b re=%0b",
                            ri, out_x, out_y, out_on_curve, out_range_err, ex[ri], ey[ri], eoc[ri], ere[ri]);
        end
        ri++;
      end
      @(posedge clk); #1;
      if (xfer) wi++;
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (ri !== 4) begin fails++; $display("FAIL b2b_count: got %0d results want 4", ri); end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= out_valid; end
    out_ready = 1'b0;
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL b2b_extra_out: got out_valid=%0b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_on_curve();
    test_off_curve();
    test_range();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
